// File: rtl/macc_sequencer.sv
// -----------------------------------------------------------------------------
// macc_sequencer
//
// Purpose:
//   Sequences one signed 8x8 dot product per job. After a start in IDLE,
//   cfg_len operand pairs are accepted over a valid/ready handshake, at up to
//   one pair per cycle. Each pair is multiplied by a radix-4 Booth multiplier
//   into a registered 16-bit product. That product is then added to an ACC_W
//   accumulator. The result is offered on a valid/ready output handshake.
//
//   States: IDLE -> RUN -> DRAIN -> DONE -> IDLE. A start with cfg_len=0 goes
//   straight from IDLE to DONE.
//
// Configuration macro:
//   MACC_SATURATE_EN - when defined, an overflowing accumulate clamps to the
//                      signed ACC_W limits. When undefined, the sum wraps
//                      modulo 2^ACC_W. In both cases the overflow sets ovf.
//
// Parameters:
//   ACC_W  - accumulator/result width (16..32), default 24
//   LEN_W  - width of the dot-product length field, default 8
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a job (only honoured in IDLE)
//   cfg_len    in   number of operand pairs, sampled with start
//   in_valid   in   operand pair present
//   in_ready   out  block accepts a pair (RUN only)
//   in_x       in   signed activation
//   in_y       in   signed weight (Booth multiplier operand)
//   out_valid  out  result available (DONE)
//   out_ready  in   consumer takes the result
//   out_acc    out  signed accumulator value
//   ovf        out  sticky signed overflow of the current job
//   busy       out  high in any state other than IDLE
// -----------------------------------------------------------------------------
module macc_sequencer #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_x,
    input  logic [7:0]       in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] cnt_inc;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]      prod_q, prod_d;
    logic             p_vld_q, p_vld_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic [15:0]      booth_p;
    logic [15:0]      x_ext;
    logic [15:0]      pp;
    logic [8:0]       y_ext;
    logic [2:0]       trip;
    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum_ext;
    logic             sum_ovf;
    logic [ACC_W-1:0] acc_sum;

    // ------------------------------------------------------------------
    // Radix-4 Booth multiplier, in_x * in_y, signed.
    // Each overlapping triplet of {in_y, 0} selects one digit in -2..+2.
    // The arithmetic is done modulo 2^16. This is exact because every
    // 8x8 signed product, including -128*-128 = +16384, fits in 16 bits.
    // ------------------------------------------------------------------
    always_comb begin
        x_ext   = {{8{in_x[7]}}, in_x};
        y_ext   = {in_y, 1'b0};
        booth_p = '0;
        trip    = '0;
        pp      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            trip = y_ext[2*i +: 3];
            case (trip)
                3'b001, 3'b010: pp = x_ext;
                3'b011:         pp = x_ext << 1;
                3'b100:         pp = -(x_ext << 1);
                3'b101, 3'b110: pp = -x_ext;
                default:        pp = '0;
            endcase
            booth_p = booth_p + (pp << (2*i));
        end
    end

    // ------------------------------------------------------------------
    // Accumulate with one guard bit. A signed overflow shows up as a
    // disagreement between the guard bit and the ACC_W MSB.
    // ------------------------------------------------------------------
    always_comb begin
        prod_ext = {{(ACC_W-15){prod_q[15]}}, prod_q};
        sum_ext  = {acc_q[ACC_W-1], acc_q} + prod_ext;
        sum_ovf  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
`ifdef MACC_SATURATE_EN
        if (sum_ovf) begin
            acc_sum = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_sum = sum_ext[ACC_W-1:0];
        end
`else
        acc_sum = sum_ext[ACC_W-1:0];
`endif
    end

    assign accept  = in_valid & in_ready_q;
    assign cnt_inc = cnt_q + 1'b1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        prod_d  = accept ? booth_p : prod_q;
        p_vld_d = accept;

        // A pending product is absorbed in whichever state it lands.
        // This is how DRAIN picks up the last product.
        if (p_vld_q) begin
            acc_d = acc_sum;
            ovf_d = ovf_q | sum_ovf;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = cfg_len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    p_vld_d = 1'b0;
                    state_d = (cfg_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The handshake flags are registered copies decoded from the next state.
        in_ready_d  = (state_d == RUN);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            p_vld_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            p_vld_q     <= p_vld_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_acc   = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_macc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_macc_sequencer
//
// Drives two macc_sequencer instances from the same stimulus: one with
// ACC_W=24 and one with ACC_W=16. A reference model computes each job's
// expected result. The expected result is pushed to a queue at start, then
// popped and compared when the DUT raises out_valid.
// -----------------------------------------------------------------------------
module tb_macc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic        out_ready;

    logic        in_ready, out_valid, ovf, busy;
    logic [23:0] out_acc;
    logic        in_ready16, out_valid16, ovf16, busy16;
    logic [15:0] out_acc16;

    int tests = 0;
    int fails = 0;

    int px[8];
    int py[8];

    typedef struct {
        longint a24;
        bit     o24;
        longint a16;
        bit     o16;
    } exp_t;
    exp_t sb[$];

    macc_sequencer #(.ACC_W(24), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .ovf(ovf), .busy(busy)
    );

    macc_sequencer #(.ACC_W(16), .LEN_W(8)) dut16 (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready16), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16),
        .ovf(ovf16), .busy(busy16)
    );

    always #5 clk = ~clk;

    // Reference dot product with the configured overflow behaviour.
    function automatic void model(input int n, input int w, output longint acc, output bit ov);
        longint mx, mn, s;
        mx  = (longint'(1) <<< (w - 1)) - 1;
        mn  = -mx - 1;
        acc = 0;
        ov  = 1'b0;
        for (int k = 0; k < n; k++) begin
            s = acc + longint'(px[k] * py[k]);
            if (s > mx || s < mn) begin
                ov = 1'b1;
`ifdef MACC_SATURATE_EN
                s = (s > mx) ? mx : mn;
`else
                s = (s > mx) ? s - 2 * (mx + 1) : s + 2 * (mx + 1);
`endif
            end
            acc = s;
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n);
        exp_t e;
        model(n, 24, e.a24, e.o24);
        model(n, 16, e.a16, e.o16);
        sb.push_back(e);
        start   = 1'b1;
        cfg_len = n[7:0];
        tick;
        start   = 1'b0;
    endtask

    task automatic send_pairs(input int n, input bit gap);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_x     = px[k][7:0];
            in_y     = py[k][7:0];
            tick;
            in_valid = 1'b0;
            if (gap) tick;
        end
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (busy !== 1'b0 || busy16 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b/%b expected 0/0", busy, busy16); end
        tests++; if (ovf !== 1'b0 || ovf16 !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b/%b expected 0/0", ovf, ovf16); end
        tests++; if (out_acc !== 24'd0 || out_acc16 !== 16'd0) begin fails++; $display("FAIL reset_out_acc: got %h/%h expected 0/0", out_acc, out_acc16); end
        tests++; if (in_ready16 !== 1'b0 || out_valid16 !== 1'b0) begin fails++; $display("FAIL reset_hs16: got %b/%b expected 0/0", in_ready16, out_valid16); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        exp_t e;
        logic signed [63:0] g;
        px[0] = 2;  py[0] = 3;
        px[1] = -4; py[1] = 5;
        px[2] = 7;  py[2] = -1;
        start_job(3);
        tests++; if (in_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL basic_run_entry: got rdy=%b busy=%b expected 1/1", in_ready, busy); end
        send_pairs(3, 1'b0);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_drop: got %b expected 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain_valid: got %b expected 0", out_valid); end
        tick;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
        e = sb.pop_front();
        g = $signed(out_acc);
        tests++; if (g !== e.a24 || e.a24 != -21) begin fails++; $display("FAIL basic_acc: got %0d expected %0d (-21)", g, e.a24); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL basic_release: got valid=%b busy=%b expected 0/0", out_valid, busy); end
    endtask

    task automatic test_min_product;
        exp_t e;
        bit to;
        logic signed [63:0] g;
        px[0] = -128; py[0] = -128;
        start_job(1);
        send_pairs(1, 1'b0);
        wait_done(to);
        tests++; if (to) begin fails++; $display("FAIL minprod_timeout: got no out_valid expected out_valid"); end
        e = sb.pop_front();
        g = $signed(out_acc);
        tests++; if (g !== e.a24 || e.a24 != 16384) begin fails++; $display("FAIL minprod_acc24: got %0d expected %0d", g, e.a24); end
        g = $signed(out_acc16);
        tests++; if (g !== e.a16) begin fails++; $display("FAIL minprod_acc16: got %0d expected %0d", g, e.a16); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_zero_len;
        exp_t e;
        logic signed [63:0] g;
        start_job(0);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL zero_out_valid: got %b expected 1", out_valid); end
        e = sb.pop_front();
        g = $signed(out_acc);
        tests++; if (g !== e.a24) begin fails++; $display("FAIL zero_acc: got %0d expected %0d", g, e.a24); end
        start   = 1'b1;
        cfg_len = 8'd5;
        tick;
        start   = 1'b0;
        tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL zero_start_ignored: got valid=%b rdy=%b expected 1/0", out_valid, in_ready); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_release: got busy=%b expected 0", busy); end
    endtask

    task automatic test_gap_stall;
        exp_t e;
        bit to;
        logic signed [63:0] g;
        logic [23:0] held;
        px[0] = 10;   py[0] = -3;
        px[1] = -7;   py[1] = -9;
        px[2] = 100;  py[2] = 50;
        px[3] = -128; py[3] = 127;
        start_job(4);
        send_pairs(4, 1'b1);
        wait_done(to);
        tests++; if (to) begin fails++; $display("FAIL gap_timeout: got no out_valid expected out_valid"); end
        e = sb.pop_front();
        g = $signed(out_acc);
        tests++; if (g !== e.a24) begin fails++; $display("FAIL gap_acc: got %0d expected %0d", g, e.a24); end
        held = out_acc;
        for (int c = 0; c < 5; c++) begin
            tick;
            tests++; if (out_valid !== 1'b1 || out_acc !== held) begin fails++; $display("FAIL gap_stall_hold: got valid=%b acc=%h expected 1/%h", out_valid, out_acc, held); end
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL gap_release: got busy=%b valid=%b expected 0/0", busy, out_valid); end
    endtask

    task automatic test_overflow(input int xv, input int yv, input string tag);
        exp_t e;
        bit to;
        logic signed [63:0] g;
        for (int k = 0; k < 3; k++) begin
            px[k] = xv;
            py[k] = yv;
        end
        start_job(3);
        tests++; if (ovf16 !== 1'b0) begin fails++; $display("FAIL %s_ovf_cleared: got %b expected 0", tag, ovf16); end
        send_pairs(3, 1'b0);
        wait_done(to);
        tests++; if (to) begin fails++; $display("FAIL %s_timeout: got no out_valid expected out_valid", tag); end
        e = sb.pop_front();
        g = $signed(out_acc);
        tests++; if (g !== e.a24 || ovf !== e.o24) begin fails++; $display("FAIL %s_acc24: got %0d ovf=%b expected %0d ovf=%b", tag, g, ovf, e.a24, e.o24); end
        g = $signed(out_acc16);
        tests++; if (g !== e.a16) begin fails++; $display("FAIL %s_acc16: got %0d expected %0d", tag, g, e.a16); end
        tests++; if (ovf16 !== e.o16) begin fails++; $display("FAIL %s_ovf16: got %b expected %b", tag, ovf16, e.o16); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        tests++; if (ovf16 !== 1'b1 || busy16 !== 1'b0) begin fails++; $display("FAIL %s_ovf_sticky: got ovf=%b busy=%b expected 1/0", tag, ovf16, busy16); end
    endtask

    task automatic test_mid_reset;
        exp_t e;
        bit to;
        logic signed [63:0] g;
        for (int k = 0; k < 4; k++) begin
            px[k] = k + 1;
            py[k] = 1;
        end
        start_job(4);
        send_pairs(2, 1'b0);
        e = sb.pop_back();
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tests++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL midrst_ctrl: got busy=%b rdy=%b valid=%b expected 0/0/0", busy, in_ready, out_valid); end
        tests++; if (out_acc !== 24'd0 || ovf !== 1'b0) begin fails++; $display("FAIL midrst_data: got acc=%h ovf=%b expected 0/0", out_acc, ovf); end
        tick;
        tests++; if (out_acc !== 24'd0) begin fails++; $display("FAIL midrst_no_absorb: got %h expected 0", out_acc); end
        px[0] = 1; py[0] = 1;
        start_job(1);
        send_pairs(1, 1'b0);
        wait_done(to);
        tests++; if (to) begin fails++; $display("FAIL midrst_timeout: got no out_valid expected out_valid"); end
        e = sb.pop_front();
        g = $signed(out_acc);
        tests++; if (g !== e.a24 || e.a24 != 1) begin fails++; $display("FAIL midrst_acc: got %0d expected %0d", g, e.a24); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_len   = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        tick;
        test_reset;
        test_basic;
        test_min_product;
        test_zero_len;
        test_gap_stall;
        test_overflow(127, 127, "pos_ovf");
        test_overflow(-128, 127, "neg_ovf");
        test_mid_reset;
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/macc_sequencer.md
MACC_SEQUENCER -- requirements
Module: macc_sequencer

Interface
REQ-001 SHALL have parameter ACC_W, default 24: accumulator and result width in bits, legal range 16..32.
REQ-002 SHALL have parameter LEN_W, default 8: width of the dot-product length field.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: begins a dot product; honoured only in IDLE.
REQ-006 SHALL have port cfg_len, input, LEN_W bits: number of operand pairs; sampled on the start edge.
REQ-007 SHALL have port in_valid, input, 1 bit: operand pair present.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a pair.
REQ-009 SHALL have port in_x, input, 8 bits: signed activation.
REQ-010 SHALL have port in_y, input, 8 bits: signed weight, the Booth multiplier operand.
REQ-011 SHALL have port out_valid, output, 1 bit: result available.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-013 SHALL have port out_acc, output, ACC_W bits: signed dot-product result.
REQ-014 SHALL have port ovf, output, 1 bit: sticky signed overflow of the current job.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-017 In IDLE, start=1 SHALL latch cfg_len, clear the accumulator, clear ovf and clear the pair counter.
REQ-018 On that start edge the next state SHALL be RUN, or DONE when cfg_len=0 (result 0).
REQ-019 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-020 in_ready SHALL be 1 only in RUN.
- A pair is accepted on an edge with in_valid & in_ready.
- in_x/in_y are don't-care otherwise.
REQ-021 On each accepting edge, a product register SHALL capture the full-range signed 16-bit product in_x*in_y and set p_vld.
- The product is computed by the radix-4 Booth multiplier.
- -128*-128 SHALL yield +16384.
REQ-022 On each edge with p_vld=1, the accumulator SHALL add the product sign-extended to ACC_W bits.
- p_vld SHALL clear unless a new pair is accepted on the same edge.
- Back-to-back pairs SHALL be accepted at one per cycle.
REQ-023 The accepting edge on which the counter reaches the latched length SHALL move RUN to DRAIN.
- in_ready SHALL be 0 from that edge on.
REQ-024 DRAIN SHALL move to DONE on the next edge, which absorbs the final product.
- out_valid therefore rises after edge E+1, where E is the last accepting edge.
REQ-025 In DONE, out_valid SHALL be 1, and out_acc and ovf SHALL hold stable until out_ready=1.
- That edge returns the block to IDLE.
REQ-026 out_acc SHALL always show the accumulator, but is valid only while out_valid=1.
REQ-027 ovf SHALL set on any accumulate edge whose exact sum exceeds the signed ACC_W range.
- ovf stays set until the next start.

Reset
REQ-028 rst=1 SHALL force, on the same edge, state IDLE with in_ready=0, out_valid=0, busy=0, ovf=0, out_acc=0, p_vld=0 and counter=0.
REQ-029 rst SHALL override start and both handshakes in every state.
- A mid-job reset aborts the job with no result.

Configuration
REQ-030 With macro MACC_SATURATE_EN defined, an overflowing accumulate SHALL clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and set ovf.
REQ-031 Without MACC_SATURATE_EN, accumulation SHALL wrap modulo 2^ACC_W and still set ovf.

Verification
REQ-032 Reset, start with cfg_len=3, pairs (2,3) (-4,5) (7,-1) back-to-back -> in_ready low after the 3rd accept; out_valid high 1 cycle later with out_acc=-21, ovf=0.
REQ-033 cfg_len=1, pair (-128,-128) -> out_acc=16384.
REQ-034 cfg_len=0 -> out_valid next cycle, out_acc=0; start pulsed while in DONE is ignored.
REQ-035 cfg_len=4 with in_valid gapped every other cycle and out_ready held low for 5 cycles -> result identical to ungapped run, out_acc stable while stalled, IDLE after out_ready.
REQ-036 ACC_W=16, cfg_len=3, pairs (127,127) x3 -> ovf=1; out_acc=32767 with MACC_SATURATE_EN, out_acc=-17149 without.
REQ-037 rst asserted in RUN after 2 of 4 pairs -> next cycle IDLE, all outputs 0; new start with cfg_len=1, pair (1,1) -> out_acc=1.
